rgb_status_tx: RTL

Reports the RGB LED state back to the host as an ASCII status line. It is the transmit-side counterpart of the RGB command FSM: it watches the same 3-bit active-low `RGB` vector and the same host command byte stream. On a query byte, or on any LED change when auto-report is enabled, it emits a 5-byte line through a valid/ready byte interface into the UART transmit path.

---
 rtl/rgb_status_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/rgb_status_tx.sv
// rgb_status_tx: reports the active-low RGB LED state to the host as a
// five-byte ASCII line ("RGB" letters or '-', then CR LF) over a
// valid/ready byte interface feeding the UART transmitter.
module rgb_status_tx #(
    parameter int QUERY_CHAR  = 63,
    parameter int AUTO_REPORT = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Cmd,
    input  logic       CmdValid,
    input  logic [2:0] RGB,
    output logic [7:0] TxData,
    output logic       TxValid,
    input  logic       TxReady,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_R,
        SEND_G,
        SEND_B,
        SEND_CR,
        SEND_LF
    } state_t;

    localparam logic [7:0] QUERY_BYTE = 8'(QUERY_CHAR);
    localparam logic [7:0] CHAR_R     = 8'd82;
    localparam logic [7:0] CHAR_G     = 8'd71;
    localparam logic [7:0] CHAR_B     = 8'd66;
    localparam logic [7:0] CHAR_DASH  = 8'd45;
    localparam logic [7:0] CHAR_CR    = 8'd13;
    localparam logic [7:0] CHAR_LF    = 8'd10;

    state_t     r_state;
    logic [2:0] r_snap;
    logic [2:0] r_last_rep;
    logic       r_pending;

    logic       w_query;
    logic       w_auto;
    logic       w_accept;
    logic       w_restart;
    state_t     w_next_state;
    logic [2:0] w_next_snap;

    // Byte presented in a given state; the LED bits are active-low.
    function automatic logic [7:0] line_byte(input state_t st, input logic [2:0] snap);
        case (st)
            SEND_R:  line_byte = snap[2] ? CHAR_DASH : CHAR_R;
            SEND_G:  line_byte = snap[1] ? CHAR_DASH : CHAR_G;
            SEND_B:  line_byte = snap[0] ? CHAR_DASH : CHAR_B;
            SEND_CR: line_byte = CHAR_CR;
            SEND_LF: line_byte = CHAR_LF;
            default: line_byte = 8'd0;
        endcase
    endfunction

    assign w_query  = CmdValid && (Cmd == QUERY_BYTE);
    assign w_auto   = (AUTO_REPORT != 0) && (RGB != r_last_rep);
    assign w_accept = TxValid && TxReady;

    // A new line starts from IDLE on a trigger, or chains straight on from
    // an accepted LF when a query is outstanding (held or arriving now) or
    // the LEDs moved since the last report.
    assign w_restart = ((r_state == IDLE) && (w_query || w_auto)) ||
                       ((r_state == SEND_LF) && w_accept && (r_pending || w_query || w_auto));

    assign w_next_snap = w_restart ? RGB : r_snap;

    // Next-state selection for the line sequencer.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_restart) w_next_state = SEND_R;
            SEND_R:  if (w_accept)  w_next_state = SEND_G;
            SEND_G:  if (w_accept)  w_next_state = SEND_B;
            SEND_B:  if (w_accept)  w_next_state = SEND_CR;
            SEND_CR: if (w_accept)  w_next_state = SEND_LF;
            SEND_LF: if (w_accept)  w_next_state = w_restart ? SEND_R : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, snapshot, pending flag and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state    <= IDLE;
            r_snap     <= 3'b111;
            r_last_rep <= 3'b111;
            r_pending  <= 1'b0;
            TxData     <= 8'd0;
            TxValid    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_snap  <= w_next_snap;
            if (w_restart) begin
                r_last_rep <= RGB;
            end
            // A restart services every outstanding query, including one
            // arriving in the LF-accept cycle itself.
            if (w_restart) begin
                r_pending <= 1'b0;
            end else if ((r_state != IDLE) && w_query) begin
                r_pending <= 1'b1;
            end
            // State and snapshot hold while stalled, so TxData holds too.
            TxData  <= line_byte(w_next_state, w_next_snap);
            TxValid <= (w_next_state != IDLE);
            Busy    <= (w_next_state != IDLE);
        end
    end

endmodule
